// File: rtl/memory_read_arbiter.sv
// memory_read_arbiter
// Shares one memory read port among N_PORTS per-core read stages. One request
// is granted per cycle (fixed priority or round-robin). The core index of every
// accepted read is kept in an in-order tag queue. Each returning word is then
// steered back to the core that issued it as a one-cycle resp_valid pulse.
module memory_read_arbiter #(
  parameter int N_PORTS     = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [N_PORTS-1:0]              req_enable,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]   req_address,
  output logic [N_PORTS-1:0]              resp_valid,
  output logic [N_PORTS*DATA_WIDTH-1:0]   resp_data,
  output logic                            mem_address_enable,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  input  logic                            mem_accept,
  input  logic                            mem_data_valid,
  input  logic [DATA_WIDTH-1:0]           mem_data,
  output logic [$clog2(DEPTH+1)-1:0]      outstanding,
  output logic                            protocol_error
);

  // Core index, queue pointer and occupancy widths. Pointers are at least one
  // bit wide so that DEPTH=1 still has a legal pointer register.
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int MEM_N = 1 << PTR_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Tag queue state. Storage is rounded up to a power of two so every pointer
  // value addresses a real entry; pointers still wrap at DEPTH.
  logic [IDX_W-1:0]  r_tag_mem [MEM_N];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_last_grant;
  logic              r_protocol_error;

  // Per-core state gathered from the per-port generate blocks.
  logic [N_PORTS-1:0]    w_pending;
  logic [N_PORTS-1:0]    w_resp_valid;

  logic [N_PORTS-1:0]    w_eligible;
  logic                  w_any;
  logic [IDX_W-1:0]      w_winner;
  logic                  w_not_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_spurious;
  logic [IDX_W-1:0]      w_head;
  logic [ADDR_WIDTH-1:0] w_mem_address;

  // A core can compete only if it is asking, has no read in flight and is not
  // receiving its response this cycle.
  assign w_eligible = req_enable & ~w_pending & ~w_resp_valid;

  // Winner selection: lowest eligible index, or first eligible index after the
  // previous grant when round-robin is enabled.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    w_any    = 1'b0;
    w_winner = '0;
    idx      = 0;
    cand     = '0;
    if (ROUND_ROBIN != 0) begin
      // Walk from the farthest candidate to the nearest so the nearest wins.
      for (int k = N_PORTS; k >= 1; k--) begin
        idx = int'(r_last_grant) + k;
        if (idx >= N_PORTS) begin
          idx = idx - N_PORTS;
        end
        cand = IDX_W'(idx);
        if (w_eligible[cand]) begin
          w_any    = 1'b1;
          w_winner = cand;
        end
      end
    end else begin
      for (int i = N_PORTS - 1; i >= 0; i--) begin
        cand = IDX_W'(i);
        if (w_eligible[cand]) begin
          w_any    = 1'b1;
          w_winner = cand;
        end
      end
    end
  end

  // Address mux: the winner's address, zero when nobody is eligible.
  always_comb begin
    w_mem_address = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_any && (w_winner == IDX_W'(i))) begin
        w_mem_address = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // The full test uses the occupancy before any pop in this cycle, so a full
  // queue never issues in the cycle it drains.
  assign w_not_full         = (r_count < CNT_FULL);
  assign mem_address_enable = reset_n && w_any && w_not_full;
  assign mem_address        = w_mem_address;

  assign w_push     = mem_address_enable && mem_accept;
  assign w_pop      = mem_data_valid && (r_count != '0);
  assign w_spurious = mem_data_valid && (r_count == '0);
  assign w_head     = r_tag_mem[r_rd_ptr];

  // Tag storage: the granted core index is written at the tail on every push.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_winner;
    end
  end

  // Queue pointers and occupancy; push and pop in the same cycle cancel out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Round-robin pointer: remembers the last accepted core. Reset points at the
  // highest index so core 0 is first in line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= LAST_IDX;
    end else if (w_push && (ROUND_ROBIN != 0)) begin
      r_last_grant <= w_winner;
    end
  end

  // Sticky error: a returning word with nothing outstanding is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_protocol_error <= 1'b0;
    end else if (w_spurious) begin
      r_protocol_error <= 1'b1;
    end
  end

  // Per-core pending flag, response pulse and held response data.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    logic                  r_pending;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  w_sel_push;
    logic                  w_sel_pop;

    assign w_sel_push = w_push && (w_winner == IDX_W'(gi));
    assign w_sel_pop  = w_pop && (w_head == IDX_W'(gi));

    // Pending is set on acceptance and cleared at the edge that ends the
    // response pulse; the pulse cycle itself still blocks a new grant.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_pending <= 1'b0;
      end else if (w_sel_push) begin
        r_pending <= 1'b1;
      end else if (r_resp_valid) begin
        r_pending <= 1'b0;
      end
    end

    // One-cycle response pulse for the core at the head of the tag queue.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_resp_valid <= 1'b0;
      end else begin
        r_resp_valid <= w_sel_pop;
      end
    end

    // Response data is captured with the pulse and held until the next one.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_resp_data <= '0;
      end else if (w_sel_pop) begin
        r_resp_data <= mem_data;
      end
    end

    assign w_pending[gi]                             = r_pending;
    assign w_resp_valid[gi]                          = r_resp_valid;
    assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH]    = r_resp_data;
  end

  assign resp_valid     = w_resp_valid;
  assign outstanding    = r_count;
  assign protocol_error = r_protocol_error;

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Testbench for memory_read_arbiter: two configurations run side by side
// (fixed priority with DEPTH=2, round-robin with DEPTH=3, three cores each).
// A driver applies directed then random stimulus and keeps a reference model;
// expected responses go into a scoreboard that a monitor checks on its own.
module tb_memory_read_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct {
    int            core;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  function automatic void chk(input int cfg, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", cfg, name, act, exp, cyc);
    end
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int N  = 3;
    localparam int D  = (gi == 0) ? 2 : 3;
    localparam int RR = gi;
    localparam int CW = $clog2(D + 1);

    logic              reset_n;
    logic [N-1:0]      req_enable;
    logic [N*AW-1:0]   req_address;
    logic [N-1:0]      resp_valid;
    logic [N*DW-1:0]   resp_data;
    logic              mem_address_enable;
    logic [AW-1:0]     mem_address;
    logic              mem_accept;
    logic              mem_data_valid;
    logic [DW-1:0]     mem_data;
    logic [CW-1:0]     outstanding;
    logic              protocol_error;

    memory_read_arbiter #(
      .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D), .ROUND_ROBIN(RR)
    ) dut (
      .clock(clk), .reset_n(reset_n),
      .req_enable(req_enable), .req_address(req_address),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_address_enable(mem_address_enable), .mem_address(mem_address),
      .mem_accept(mem_accept), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
      .outstanding(outstanding), .protocol_error(protocol_error)
    );

    // Reference model: per-core pending/response flags, tag order, memory due times.
    exp_t          sb[$];
    bit [N-1:0]    m_pend;
    bit [N-1:0]    m_rv;
    int            m_last;
    int            m_tags[$];
    int            m_due[$];
    bit            m_perr;
    logic [AW-1:0] addr_v [N];
    int            lat;
    bit            hold;
    logic [DW-1:0] next_d;
    logic          o_en;
    logic [AW-1:0] o_addr;
    int            o_out;
    logic          o_perr;

    // One clock cycle of stimulus; combinational outputs compared at negedge.
    task automatic step(input logic [N-1:0] en, input bit acc, input bit spur, input bit rnd_data);
      bit [N-1:0]    elig;
      bit            any;
      int            win;
      int            c;
      int            h;
      bit            exp_en;
      logic [AW-1:0] exp_addr;
      int            exp_out;
      bit            exp_perr;
      bit            dv;
      logic [DW-1:0] d;
      @(posedge clk); #1;
      dv = spur || (!hold && m_due.size() > 0 && m_due[0] <= cyc);
      d  = rnd_data ? DW'($urandom) : next_d;
      reset_n        = 1'b1;
      req_enable     = en;
      mem_accept     = acc;
      mem_data_valid = dv;
      mem_data       = d;
      for (int i = 0; i < N; i++) req_address[i*AW +: AW] = addr_v[i];
      // Expected grant from the eligibility and ordering rules.
      elig = en & ~m_pend & ~m_rv;
      any  = 1'b0;
      win  = 0;
      for (int k = 1; k <= N; k++) begin
        c = (RR != 0) ? (m_last + k) % N : k - 1;
        if (!any && elig[c]) begin
          any = 1'b1;
          win = c;
        end
      end
      exp_en   = any && (m_tags.size() < D);
      exp_addr = any ? addr_v[win] : '0;
      exp_out  = m_tags.size();
      exp_perr = m_perr;
      // Advance the model across the coming edge.
      for (int i = 0; i < N; i++) if (m_rv[i]) m_pend[i] = 1'b0;
      m_rv = '0;
      if (dv) begin
        if (m_tags.size() > 0) begin
          h = m_tags.pop_front();
          void'(m_due.pop_front());
          m_rv[h] = 1'b1;
          sb.push_back('{h, d, cyc + 1});
        end else begin
          m_perr = 1'b1;
        end
        if (!rnd_data) next_d = next_d + 1'b1;
      end
      if (exp_en && acc) begin
        m_tags.push_back(win);
        m_due.push_back(cyc + lat);
        m_pend[win] = 1'b1;
        if (RR != 0) m_last = win;
      end
      @(negedge clk);
      o_en   = mem_address_enable;
      o_addr = mem_address;
      o_out  = int'(outstanding);
      o_perr = protocol_error;
      chk(gi, "mem_address_enable", o_en, exp_en);
      chk(gi, "mem_address", o_addr, exp_addr);
      chk(gi, "outstanding", o_out, exp_out);
      chk(gi, "protocol_error", o_perr, exp_perr);
    endtask

    // Hold reset low for n cycles (asserted mid-cycle) and check reset outputs.
    task automatic reset_cycles(input int n, input logic [N-1:0] en);
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
        reset_n        = 1'b0;
        req_enable     = en;
        mem_accept     = 1'b1;
        mem_data_valid = 1'b0;
        m_pend = '0; m_rv = '0; m_last = N - 1; m_perr = 1'b0; hold = 1'b0;
        m_tags.delete(); m_due.delete(); sb.delete();
        @(negedge clk);
        chk(gi, "rst_mem_address_enable", mem_address_enable, 1'b0);
        chk(gi, "rst_outstanding", outstanding, 0);
        chk(gi, "rst_protocol_error", protocol_error, 1'b0);
      end
    endtask

    task automatic drain();
      hold = 1'b0;
      for (int k = 0; k < 40 && m_tags.size() > 0; k++) step('0, 1'b0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0, 1'b0);
    endtask

    // Driver: directed scenarios then random traffic.
    initial begin
      reset_n = 1'b0; req_enable = '0; req_address = '0; mem_accept = 1'b0;
      mem_data_valid = 1'b0; mem_data = '0;
      lat = 2; hold = 1'b0; next_d = 16'h000A;
      for (int i = 0; i < N; i++) addr_v[i] = AW'(16'h100 * (i + 1));
      reset_cycles(2, '0);

      // Two cores request together; memory answers 2 cycles after each accept.
      step(3'b011, 1'b1, 1'b0, 1'b0);
      chk(gi, "first_grant_addr", o_addr, 16'h100);
      step(3'b011, 1'b1, 1'b0, 1'b0);
      chk(gi, "second_grant_addr", o_addr, 16'h200);
      step(3'b011, 1'b0, 1'b0, 1'b0);
      step(3'b011, 1'b0, 1'b0, 1'b0);
      step(3'b010, 1'b0, 1'b0, 1'b0);
      drain();

      // All cores re-request continuously.
      lat = 1;
      repeat (12) step(3'b111, 1'b1, 1'b0, 1'b0);
      drain();

      // Fill the queue while memory withholds data, then release it.
      hold = 1'b1;
      lat  = 1;
      repeat (D) step(3'b111, 1'b1, 1'b0, 1'b0);
      step(3'b111, 1'b1, 1'b0, 1'b0);
      chk(gi, "full_outstanding", o_out, D);
      chk(gi, "full_no_issue", o_en, 1'b0);
      hold = 1'b0;
      step(3'b111, 1'b1, 1'b0, 1'b0);
      chk(gi, "full_pop_cycle_no_issue", o_en, 1'b0);
      step(3'b111, 1'b1, 1'b0, 1'b0);
      chk(gi, "full_resume", o_en, N > D);
      drain();

      // Core 0 drops its request while pending, then asks again.
      lat = 2;
      step(3'b001, 1'b1, 1'b0, 1'b0);
      repeat (5) step(3'b000, 1'b0, 1'b0, 1'b0);
      step(3'b001, 1'b1, 1'b0, 1'b0);
      chk(gi, "flush_regrant_en", o_en, 1'b1);
      chk(gi, "flush_regrant_addr", o_addr, 16'h100);
      drain();

      // Spurious memory word with nothing outstanding.
      step(3'b000, 1'b0, 1'b1, 1'b0);
      step(3'b000, 1'b0, 1'b0, 1'b0);
      chk(gi, "spurious_error_set", o_perr, 1'b1);
      step(3'b000, 1'b0, 1'b0, 1'b0);
      chk(gi, "spurious_error_sticky", o_perr, 1'b1);
      reset_cycles(1, '0);
      step(3'b000, 1'b0, 1'b0, 1'b0);
      chk(gi, "error_cleared", o_perr, 1'b0);

      // Reset with a full set of tags in flight.
      hold = 1'b1;
      repeat (D) step(3'b111, 1'b1, 1'b0, 1'b0);
      reset_cycles(2, 3'b111);
      step(3'b011, 1'b1, 1'b0, 1'b0);
      chk(gi, "post_reset_en", o_en, 1'b1);
      chk(gi, "post_reset_addr", o_addr, 16'h100);
      drain();

      // Random traffic.
      repeat (600) begin
        for (int i = 0; i < N; i++) addr_v[i] = AW'($urandom);
        lat = $urandom_range(4, 1);
        if ($urandom_range(99, 0) < 5) hold = !hold;
        step(N'($urandom) | N'($urandom), ($urandom_range(9, 0) < 7), 1'b0, 1'b1);
      end
      drain();
      n_done++;
    end

    // Monitor: pops the scoreboard whenever a response is due and checks the
    // full resp_valid / resp_data vectors every cycle.
    logic [DW-1:0] held [N];
    initial for (int i = 0; i < N; i++) held[i] = '0;

    always @(negedge clk) begin
      logic [N-1:0]    exp_rv;
      logic [N*DW-1:0] exp_data;
      exp_t            e;
      exp_rv = '0;
      if (!reset_n) begin
        for (int i = 0; i < N; i++) held[i] = '0;
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        exp_rv[e.core] = 1'b1;
        held[e.core]   = e.data;
        $display("cfg%0d cycle %0d response core %0d data 0x%0h", gi, cyc, e.core, e.data);
      end
      for (int i = 0; i < N; i++) exp_data[i*DW +: DW] = held[i];
      chk(gi, "resp_valid", resp_valid, exp_rv);
      chk(gi, "resp_data", resp_data, exp_data);
    end
  end

  initial begin
    for (int k = 0; k < 20000 && n_done < 2; k++) @(posedge clk);
    chk(-1, "run_complete", n_done, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
